// File: rtl/mul3_pkg.sv
// Shared definitions for the multiply-by-3 recombiner and its companion divider.
// State encodings and the fixed remainder width live here so both sides agree.
package mul3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL3_CONST     = 3;
    localparam int DIVIDEND_WIDTH = 2;

    // True when a (W+2)-bit result does not fit back into W bits.
    function automatic logic upper_nonzero(input logic [1:0] top_bits);
        return |top_bits;
    endfunction

endpackage

// File: rtl/mul3_step.sv
// One bit-serial step of 3*q + r: shift the accumulator, add 3 for a set quotient bit,
// and fold in the remainder on the final step.
module mul3_step
    import mul3_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W+1:0]                acc,
    input  logic                        q_bit,
    input  logic                        add_r,
    input  logic [DIVIDEND_WIDTH-1:0]   r,
    output logic [W+1:0]                acc_next
);

    always_comb begin
        acc_next = acc << 1;
        if (q_bit) begin
            acc_next = acc_next + (W+2)'(MUL3_CONST);
        end
        if (add_r) begin
            acc_next = acc_next + (W+2)'(r);
        end
    end

endmodule

// File: rtl/mul3_recombiner.sv
// Rebuilds a linear index from (quotient, remainder) as 3*quotient + remainder,
// consuming one quotient bit per cycle, MSB first, with valid/ready on both sides.
module mul3_recombiner #(
    parameter int DIVISOR_WIDTH  = 8,
    parameter int DIVIDEND_WIDTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DIVISOR_WIDTH-1:0]               quotient,
    input  logic [DIVIDEND_WIDTH-1:0]              remainders,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DIVISOR_WIDTH+DIVIDEND_WIDTH-1:0] value,
    output logic                                   overflow,
    output logic                                   rem_err,
    output logic                                   busy
);
    import mul3_pkg::*;

    localparam int W  = DIVISOR_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t                    state;
    logic [W-1:0]              q_sh;
    logic [DIVIDEND_WIDTH-1:0] r_reg;
    logic [W+1:0]              acc;
    logic [W+1:0]              acc_next;
    logic [CW-1:0]             cnt;
    logic                      last_step;

    assign last_step = (cnt == '0);

    mul3_step #(.W(W)) u_step (
        .acc      (acc),
        .q_bit    (q_sh[W-1]),
        .add_r    (last_step),
        .r        (r_reg),
        .acc_next (acc_next)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q_sh     <= '0;
            r_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            value    <= '0;
            overflow <= 1'b0;
            rem_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_sh    <= quotient;
                        r_reg   <= remainders;
                        acc     <= '0;
                        cnt     <= CW'(W - 1);
                        rem_err <= (remainders == DIVIDEND_WIDTH'(3));
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    q_sh <= q_sh << 1;
                    if (last_step) begin
                        value    <= acc_next;
                        overflow <= upper_nonzero(acc_next[W+1:W]);
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Result registers hold until the consumer takes them.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul3_recombiner.sv
// Self-checking bench for mul3_recombiner: directed corner cases plus a randomized
// producer/consumer run scored against plain 3*q + r arithmetic.
module tb_mul3_recombiner;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quotient = '0;
    logic [1:0]     remainders = '0;
    logic           in_ready;
    logic           out_valid;
    logic [W+1:0]   value;
    logic           overflow;
    logic           rem_err;
    logic           busy;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    mul3_recombiner #(.DIVISOR_WIDTH(W), .DIVIDEND_WIDTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .quotient   (quotient),
        .remainders (remainders),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .value      (value),
        .overflow   (overflow),
        .rem_err    (rem_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one pair and returns once the accept edge has passed.
    task automatic start_op(input int q, input int r, output bit ok);
        quotient   = 8'(q);
        remainders = 2'(r);
        in_valid   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (value !== 10'd0) begin fails++; $display("FAIL reset_value got %0d want 0", value); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b want 0", overflow); end
        tests++; if (rem_err !== 1'b0) begin fails++; $display("FAIL reset_rem_err got %b want 0", rem_err); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        out_ready = 1'b1;
        start_op(42, 2, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_accept got %b want 1", ok); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b want 1", busy); end
        wait_done(lat);
        tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency got %0d want 8", lat); end
        tests++; if (value !== 10'd128) begin fails++; $display("FAIL basic_value got %0d want 128", value); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_overflow got %b want 0", overflow); end
        tests++; if (rem_err !== 1'b0) begin fails++; $display("FAIL basic_rem_err got %b want 0", rem_err); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_one_cycle got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_boundaries();
        int tq[5]   = '{0, 255, 85, 5, 1};
        int tr[5]   = '{0, 2, 1, 3, 0};
        int tv[5]   = '{0, 767, 256, 18, 3};
        bit tov[5]  = '{0, 1, 1, 0, 0};
        bit terr[5] = '{0, 0, 0, 1, 0};
        bit ok;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start_op(tq[i], tr[i], ok);
            wait_done(lat);
            tests++; if (lat != 8) begin fails++; $display("FAIL bound_latency[%0d] got %0d want 8", i, lat); end
            tests++; if (value !== 10'(tv[i])) begin fails++; $display("FAIL bound_value[%0d] got %0d want %0d", i, value, tv[i]); end
            tests++; if (overflow !== tov[i]) begin fails++; $display("FAIL bound_overflow[%0d] got %b want %b", i, overflow, tov[i]); end
            tests++; if (rem_err !== terr[i]) begin fails++; $display("FAIL bound_rem_err[%0d] got %b want %b", i, rem_err, terr[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        out_ready = 1'b0;
        start_op(200, 1, ok);
        wait_done(lat);
        tests++; if (lat != 8) begin fails++; $display("FAIL bp_latency got %0d want 8", lat); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            tests++; if (value !== 10'd601) begin fails++; $display("FAIL bp_value[%0d] got %0d want 601", i, value); end
            tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow[%0d] got %b want 1", i, overflow); end
            tests++; if (rem_err !== 1'b0) begin fails++; $display("FAIL bp_rem_err[%0d] got %b want 0", i, rem_err); end
            quotient   = 8'($urandom);
            remainders = 2'd3;
            in_valid   = (i % 2 == 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests++; if (value !== 10'd601) begin fails++; $display("FAIL bp_value_final got %0d want 601", value); end
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
        tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_no_spurious_op got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        out_ready = 1'b1;
        start_op(77, 2, ok);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        tests++; if (value !== 10'd0) begin fails++; $display("FAIL rst_mid_value got %0d want 0", value); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_mid_overflow got %b want 0", overflow); end
        #2 rst_n = 1'b1;
        tick();
        start_op(10, 1, ok);
        wait_done(lat);
        tests++; if (lat != 8) begin fails++; $display("FAIL rst_fresh_latency got %0d want 8", lat); end
        tests++; if (value !== 10'd31) begin fails++; $display("FAIL rst_fresh_value got %0d want 31", value); end
        tests++; if (rem_err !== 1'b0) begin fails++; $display("FAIL rst_fresh_rem_err got %b want 0", rem_err); end
        tick();
    endtask

    task automatic test_random();
        localparam int N = 1500;
        exp_q.delete();
        fork
            begin : producer
                int q;
                int r;
                int gap;
                bit accepted;
                for (int i = 0; i < N; i++) begin
                    gap = $urandom_range(0, 3);
                    repeat (gap) tick();
                    q = $urandom_range(0, 255);
                    r = $urandom_range(0, 2);
                    quotient   = 8'(q);
                    remainders = 2'(r);
                    in_valid   = 1'b1;
                    accepted   = 1'b0;
                    for (int k = 0; k < 200 && !accepted; k++) begin
                        if (in_ready) begin
                            accepted = 1'b1;
                            exp_q.push_back(3 * q + r);
                        end
                        tick();
                    end
                    in_valid = 1'b0;
                    tests++;
                    if (!accepted) begin
                        fails++;
                        $display("FAIL rand_accept_timeout op %0d got no in_ready want accept", i);
                        break;
                    end
                end
            end
            begin : consumer
                int got;
                int guard;
                int e;
                got = 0;
                guard = 0;
                while (got < N && guard < 40000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        tests++;
                        if (exp_q.size() == 0) begin
                            fails++;
                            $display("FAIL rand_extra_result got %0d want none", value);
                        end else begin
                            e = exp_q.pop_front();
                            if (value !== 10'(e)) begin fails++; $display("FAIL rand_value[%0d] got %0d want %0d", got, value, e); end
                            tests++;
                            if (overflow !== ((e >> 8) != 0)) begin fails++; $display("FAIL rand_overflow[%0d] got %b want %b", got, overflow, ((e >> 8) != 0)); end
                            tests++;
                            if (rem_err !== 1'b0) begin fails++; $display("FAIL rand_rem_err[%0d] got %b want 0", got, rem_err); end
                        end
                        got++;
                    end
                    tick();
                    guard++;
                end
                out_ready = 1'b1;
                tests++;
                if (got != N) begin fails++; $display("FAIL rand_result_count got %0d want %0d", got, N); end
            end
        join
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
